// File: rtl/icache_pkg.sv
// ----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction-cache fetch responder.
//   - Geometry constants (address, line, block and field widths)
//   - FSM state encoding for the refill controller
//   - word_sel(): picks one 32-bit instruction word out of a cache block
// Fetch address layout (defaults):
//   [31:7] tag | [6:4] index | [3:2] word offset | [1:0] byte (ignored)
// ----------------------------------------------------------------------------
package icache_pkg;

   localparam int ADDR_W      = 32;
   localparam int NUM_LINES   = 8;
   localparam int BLOCK_WORDS = 4;

   localparam int OFFSET_W   = $clog2(BLOCK_WORDS);
   localparam int INDEX_W    = $clog2(NUM_LINES);
   localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W - 2;
   localparam int MEM_ADDR_W = TAG_W + INDEX_W;
   localparam int BLOCK_W    = 32 * BLOCK_WORDS;

   // Bit positions of each field inside the fetch address.
   localparam int OFF_LSB = 2;
   localparam int IDX_LSB = OFF_LSB + OFFSET_W;
   localparam int TAG_LSB = IDX_LSB + INDEX_W;

   typedef enum logic [1:0] {
      IDLE,
      MEM_FETCH,
      UPDATE
   } state_e;

   // Word 0 lives in bits [31:0] of the block.
   function automatic logic [31:0] word_sel(input logic [BLOCK_W-1:0]  blk,
                                            input logic [OFFSET_W-1:0] off);
      return blk[{off, 5'b0} +: 32];
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// ----------------------------------------------------------------------------
// icache_line_store
// Valid/tag/data storage for the direct-mapped instruction cache.
// One synchronous write port (whole line at once) and one combinational
// read port. Only the valid bits are cleared by reset.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears all valid bits)
//   we        write enable: store wr_tag/wr_data in line wr_index, mark valid
//   wr_index  line being refilled
//   wr_tag    tag of the refilled block
//   wr_data   refilled block
//   rd_index  line addressed by the current fetch
//   rd_valid  valid bit of that line
//   rd_tag    stored tag of that line
//   rd_data   stored block of that line
// ----------------------------------------------------------------------------
module icache_line_store
   import icache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [INDEX_W-1:0] wr_index,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [BLOCK_W-1:0] wr_data,
   input  logic [INDEX_W-1:0] rd_index,
   output logic               rd_valid,
   output logic [TAG_W-1:0]   rd_tag,
   output logic [BLOCK_W-1:0] rd_data
);

   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [TAG_W-1:0]     tag_d  [NUM_LINES];
   logic [BLOCK_W-1:0]   data_q [NUM_LINES];
   logic [BLOCK_W-1:0]   data_d [NUM_LINES];

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (we) begin
         valid_d[wr_index] = 1'b1;
         tag_d[wr_index]   = wr_tag;
         data_d[wr_index]  = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // NOTE: tag and data arrays are deliberately not reset; a line is only
   // ever read through its valid bit, so clearing valid is sufficient.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache_fetch_responder.sv
// ----------------------------------------------------------------------------
// icache_fetch_responder
// Direct-mapped, read-only instruction cache between the PC/fetch stage and
// instruction memory. Hits return the instruction combinationally with no
// stall; a miss raises BUSY_WAIT in the same cycle and refills the whole
// block through a level-held MEM_READ / MEM_BUSYWAIT handshake
// (IDLE -> MEM_FETCH -> UPDATE -> IDLE, where the access then hits).
// Optional build macro ICACHE_PERF_EN adds HIT_COUNT / MISS_COUNT outputs.
// Ports:
//   CLK           rising-edge clock
//   RESET         synchronous active-high reset; forces BUSY_WAIT/MEM_READ low
//   READ          fetch request valid
//   ADDRESS       fetch address (PC), bits [1:0] ignored
//   INSTRUCTION   fetched word; valid when READ=1 and BUSY_WAIT=0, held otherwise
//   BUSY_WAIT     stall to the PC unit
//   MEM_READ      block read request to instruction memory
//   MEM_ADDRESS   block address {tag,index} of the refill
//   MEM_READDATA  refill block, word 0 in bits [31:0]
//   MEM_BUSYWAIT  memory busy; data valid in the MEM_FETCH cycle it is low
//   HIT_COUNT     (ICACHE_PERF_EN) IDLE cycles with READ and a hit
//   MISS_COUNT    (ICACHE_PERF_EN) refills started
// ----------------------------------------------------------------------------
module icache_fetch_responder
   import icache_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  READ,
   input  logic [ADDR_W-1:0]     ADDRESS,
   output logic [31:0]           INSTRUCTION,
   output logic                  BUSY_WAIT,
   output logic                  MEM_READ,
   output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
   input  logic [BLOCK_W-1:0]    MEM_READDATA,
   input  logic                  MEM_BUSYWAIT
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0]           HIT_COUNT,
   output logic [31:0]           MISS_COUNT
`endif
);

   // ---------------------------------------------------------------------
   // Fetch address fields
   // ---------------------------------------------------------------------
   logic [OFFSET_W-1:0] fetch_offset;
   logic [INDEX_W-1:0]  fetch_index;
   logic [TAG_W-1:0]    fetch_tag;
   logic                byte_sel_unused;

   assign fetch_offset    = ADDRESS[IDX_LSB-1:OFF_LSB];
   assign fetch_index     = ADDRESS[TAG_LSB-1:IDX_LSB];
   assign fetch_tag       = ADDRESS[ADDR_W-1:TAG_LSB];
   assign byte_sel_unused = ^ADDRESS[OFF_LSB-1:0];

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e                state_q, state_d;
   logic [MEM_ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [BLOCK_W-1:0]    block_q, block_d;
   logic [31:0]           instr_q, instr_d;

   logic                  line_valid;
   logic [TAG_W-1:0]      line_tag;
   logic [BLOCK_W-1:0]    line_data;
   logic                  line_we;

   logic                  hit;
   logic                  miss;
   logic                  busy;
   logic                  mem_rd;

   icache_line_store u_line_store (
      .clk      (CLK),
      .rst      (RESET),
      .we       (line_we),
      .wr_index (req_addr_q[INDEX_W-1:0]),
      .wr_tag   (req_addr_q[MEM_ADDR_W-1:INDEX_W]),
      .wr_data  (block_q),
      .rd_index (fetch_index),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data)
   );

   assign hit  = READ & line_valid & (line_tag == fetch_tag);
   assign miss = READ & ~hit;

   // ---------------------------------------------------------------------
   // Refill controller: next state and outputs
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // through the case statement can leave a latch behind.
      state_d    = state_q;
      req_addr_d = req_addr_q;
      block_d    = block_q;
      instr_d    = instr_q;
      busy       = 1'b0;
      mem_rd     = 1'b0;
      line_we    = 1'b0;

      case (state_q)
         IDLE: begin
            // A hit updates the held instruction; otherwise it keeps the
            // last delivered word (READ=0 or a miss).
            if (hit) begin
               instr_d = word_sel(line_data, fetch_offset);
            end
            if (miss) begin
               busy       = 1'b1;
               req_addr_d = {fetch_tag, fetch_index};
               state_d    = MEM_FETCH;
            end
         end

         MEM_FETCH: begin
            busy   = 1'b1;
            mem_rd = 1'b1;
            if (!MEM_BUSYWAIT) begin
               block_d = MEM_READDATA;
               state_d = UPDATE;
            end
         end

         UPDATE: begin
            // Line is written at the end of this cycle; the access is then
            // re-evaluated in IDLE against the refilled line.
            busy    = 1'b1;
            line_we = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of its inputs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         req_addr_q <= '0;
         instr_q    <= '0;
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
         instr_q    <= instr_d;
      end
   end

   // Refill staging register: only consumed in UPDATE, after it is loaded.
   always_ff @(posedge CLK) begin
      block_q <= block_d;
   end

   // Reset overrides the handshake outputs immediately, so a refill in
   // flight is abandoned at the reset edge.
   assign BUSY_WAIT   = busy & ~RESET;
   assign MEM_READ    = mem_rd & ~RESET;
   assign MEM_ADDRESS = req_addr_q;
   assign INSTRUCTION = RESET ? 32'h0000_0000 : instr_d;

`ifdef ICACHE_PERF_EN
   // ---------------------------------------------------------------------
   // Performance counters (wrap at 2^32)
   // ---------------------------------------------------------------------
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;

   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (state_q == IDLE) begin
         if (hit) begin
            hit_count_d = hit_count_q + 32'd1;
         end
         if (miss) begin
            miss_count_d = miss_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign HIT_COUNT  = hit_count_q;
   assign MISS_COUNT = miss_count_q;
`endif

endmodule
